matmul_dma_engine: RTL and testbench
====================================

// Module: matmul_dma_engine
// PURPOSE
//  Runtime-dimensioned matrix multiply engine on the shared 32-bit memory bus: C[MxN] = A[MxK] * B[KxN].
//  Fetches A and B into local buffers, computes with one sequential signed MAC, writes C back.
//  Dimensions, base addresses and row strides are latched per job.
//  Sits beside the RISC-V core as a bus master and reports busy/done/err.
// PARAMETERS
//  MAX_DIM    4   max value of M, K, N; local buffers are MAX_DIM x MAX_DIM words each
//  DIM_W      3   width of the dim_*_i ports; must hold MAX_DIM
//  STRIDE_W   16  width of the byte-stride ports
// PORTS
//  clk_i        in   1         clock, rising edge
//  rst_i        in   1         reset, asynchronous, active-high
//  start_i      in   1         job start; sampled only in IDLE
//  dim_m_i      in   DIM_W     rows of A and C
//  dim_k_i      in   DIM_W     cols of A = rows of B
//  dim_n_i      in   DIM_W     cols of B and C
//  addr_a_i     in   32        byte base of A (word aligned)
//  addr_b_i     in   32        byte base of B (word aligned)
//  addr_c_i     in   32        byte base of C (word aligned)
//  stride_a_i   in   STRIDE_W  byte distance between A rows
//  stride_b_i   in   STRIDE_W  byte distance between B rows
//  stride_c_i   in   STRIDE_W  byte distance between C rows
//  busy_o       out  1         high from the cycle after an accepted start until DONE
//  done_o       out  1         1-cycle pulse when the last C write is acked
//  err_o        out  1         1-cycle pulse on a rejected start
//  mem_req_o    out  1         bus request
//  mem_we_o     out  1         1 = write, 0 = read
//  mem_be_o     out  4         byte enables; 4'hF on writes, 4'h0 on reads
//  mem_addr_o   out  32        byte address
//  mem_wdata_o  out  32        write data
//  mem_rdata_i  in   32        read data, valid with mem_ack_i
//  mem_gnt_i    in   1         request accepted this cycle
//  mem_ack_i    in   1         transfer complete (read data valid)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM to IDLE, counters 0. Buffer contents undefined.
//  - Reset mid-job aborts immediately. No done_o pulse is produced.
//  - States and transitions:
//    IDLE   -> LOAD_A  on start_i with 1 <= M,K,N <= MAX_DIM. Dims, addresses and strides are latched.
//    IDLE   -> IDLE    on start_i with any dim 0 or > MAX_DIM. err_o pulses next cycle; no bus traffic.
//    LOAD_A -> LOAD_B  after M*K words are acked.
//    LOAD_B -> MAC     after K*N words are acked.
//    MAC    -> WRITE   after K accumulate cycles for element (i,j).
//    WRITE  -> MAC     on ack of C(i,j) when elements remain.
//    WRITE  -> DONE    on ack of the last element.
//    DONE   -> IDLE    unconditionally; done_o = 1 and busy_o = 0 in this cycle.
//  - Traversal is row-major: A by (i,k), B by (k,j), C by (i,j).
//  - Addressing: elem(r,c) = base + r*stride + 4*c, 32-bit wrap-around, no bounds check.
//  - Bus handshake: one outstanding transfer at a time.
//    mem_req_o, mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o are registered and held stable until mem_gnt_i.
//    mem_req_o drops in the cycle after the grant; the engine then waits for mem_ack_i.
//    The next request is issued no earlier than the cycle after the ack.
//    mem_ack_i without an outstanding transfer is ignored.
//    gnt and ack in the same cycle is legal.
//  - Arithmetic: operands are signed 32-bit; products are signed 64-bit.
//    The accumulator is 64+$clog2(MAX_DIM)+1 bits and is cleared at the start of each element.
//    MAC latency per element is exactly K cycles.
//  - C word = accumulator[31:0] (truncation) unless the saturation feature is compiled in.
//  - start_i while busy is ignored: no err_o, latched config unchanged.
// CONFIGURATION
//  MATMUL_SAT_EN defined:
//    C word saturates to 32'h7FFFFFFF / 32'h80000000 when the accumulator exceeds signed 32-bit range.
//    A sticky status bit sat_o (out, 1) is added. It is set on any saturation, cleared on an accepted start, 0 at reset.
//  MATMUL_SAT_EN undefined:
//    Plain truncation; no sat_o port.
// TESTING
//  1. M=2,K=3,N=2, A=[1 2 3;4 5 6], B=[7 8;9 10;11 12], strides 12/8/8, zero-wait bus
//     -> C=[58 64;139 154] at addr_c, single done_o pulse.
//  2. Same job with mem_gnt_i delayed 0-5 random cycles and ack delayed 1-4 cycles
//     -> identical C; req/addr/data stable until gnt; never two outstanding transfers.
//  3. Start with dim_k_i=0, then with dim_m_i=MAX_DIM+1
//     -> err_o pulses once per start, mem_req_o stays 0, busy_o stays 0.
//  4. 1x1x1 job, A=32'h7FFFFFFF, B=2
//     -> without MATMUL_SAT_EN C=32'hFFFFFFFE; with it C=32'h7FFFFFFF and sat_o=1.
//  5. Assert rst_i during LOAD_B, release, start 1x1x1 job 3*-4
//     -> outputs 0 during reset, no done_o for the aborted job, C=32'hFFFFFFF4.
//  6. Pulse start_i during MAC with different addresses -> ignored; C is written only to the original addr_c.

Source files
------------

// File: rtl/matmul_dma_engine.sv
// matmul_dma_engine: bus-mastering matrix multiply engine, C[MxN] = A[MxK] * B[KxN].
// Loads A and B into local buffers over a one-outstanding-transfer bus,
// runs one signed MAC per cycle (K cycles per element), then writes each C element back.
// Optional feature macro: MATMUL_SAT_EN (saturating C words plus sticky sat_o flag).
module matmul_dma_engine #(
  parameter int MAX_DIM  = 4,
  parameter int DIM_W    = 3,
  parameter int STRIDE_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [DIM_W-1:0]    dim_m_i,
  input  logic [DIM_W-1:0]    dim_k_i,
  input  logic [DIM_W-1:0]    dim_n_i,
  input  logic [31:0]         addr_a_i,
  input  logic [31:0]         addr_b_i,
  input  logic [31:0]         addr_c_i,
  input  logic [STRIDE_W-1:0] stride_a_i,
  input  logic [STRIDE_W-1:0] stride_b_i,
  input  logic [STRIDE_W-1:0] stride_c_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
`ifdef MATMUL_SAT_EN
  output logic                sat_o,
`endif
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [3:0]          mem_be_o,
  output logic [31:0]         mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  input  logic [31:0]         mem_rdata_i,
  input  logic                mem_gnt_i,
  input  logic                mem_ack_i
);

  localparam int ACC_W = 64 + $clog2(MAX_DIM) + 1;
  localparam int BUF_D = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(BUF_D);
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_MAC, S_WRITE, S_DONE
  } state_t;

  // Bus sub-phase for the load/write states: issue a request, wait for the
  // grant, then wait for the ack.
  typedef enum logic [1:0] {
    PH_ISSUE, PH_REQ, PH_ACK
  } phase_t;

  state_t                state_q;
  phase_t                ph_q;
  logic [DIM_W-1:0]      m_q, k_q, n_q;
  logic [31:0]           base_a_q, base_b_q, base_c_q;
  logic [STRIDE_W-1:0]   stride_a_q, stride_b_q, stride_c_q;
  logic [DIM_W-1:0]      row_q, col_q, kk_q;
  logic [ACC_W-1:0]      acc_q;

  logic                  busy_q, done_q, err_q;
  logic                  req_q, we_q;
  logic [3:0]            be_q;
  logic [31:0]           addr_q, wdata_q;
`ifdef MATMUL_SAT_EN
  logic                  sat_q;
`endif

  // Local operand buffers, indexed row*MAX_DIM + col.
  logic [31:0]           a_buf_q [BUF_D];
  logic [31:0]           b_buf_q [BUF_D];

  logic                  xfer_done;
  logic                  dims_ok;
  logic [31:0]           sel_base;
  logic [STRIDE_W-1:0]   sel_stride;
  logic [DIM_W-1:0]      row_lim, col_lim;
  logic                  row_last, col_last;
  logic [31:0]           elem_addr;
  logic [IDX_W-1:0]      wr_idx, a_rd_idx, b_rd_idx;
  logic                  a_we, b_we;
  logic [31:0]           op_a, op_b;
  logic [63:0]           prod;
  logic [ACC_W-1:0]      acc_add;
  logic [31:0]           c_word;
  logic                  c_ovf;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
`ifdef MATMUL_SAT_EN
  assign sat_o       = sat_q;
`endif

  // A transfer completes on an ack while one is outstanding (grant may coincide).
  assign xfer_done = ((ph_q == PH_REQ) && mem_gnt_i && mem_ack_i) ||
                     ((ph_q == PH_ACK) && mem_ack_i);

  assign dims_ok = (dim_m_i != '0) && (dim_m_i <= DIM_W'(MAX_DIM)) &&
                   (dim_k_i != '0) && (dim_k_i <= DIM_W'(MAX_DIM)) &&
                   (dim_n_i != '0) && (dim_n_i <= DIM_W'(MAX_DIM));

  // Select which matrix the row/col counters walk and build its element address.
  always_comb begin
    sel_base   = base_c_q;
    sel_stride = stride_c_q;
    row_lim    = m_q;
    col_lim    = n_q;
    case (state_q)
      S_LOAD_A: begin
        sel_base   = base_a_q;
        sel_stride = stride_a_q;
        row_lim    = m_q;
        col_lim    = k_q;
      end
      S_LOAD_B: begin
        sel_base   = base_b_q;
        sel_stride = stride_b_q;
        row_lim    = k_q;
        col_lim    = n_q;
      end
      default: ;
    endcase
    elem_addr = sel_base + (32'(row_q) * 32'(sel_stride)) + (32'(col_q) << 2);
    row_last  = (row_q == row_lim - ONE);
    col_last  = (col_q == col_lim - ONE);
  end

  assign wr_idx   = IDX_W'(row_q) * IDX_W'(MAX_DIM) + IDX_W'(col_q);
  assign a_rd_idx = IDX_W'(row_q) * IDX_W'(MAX_DIM) + IDX_W'(kk_q);
  assign b_rd_idx = IDX_W'(kk_q)  * IDX_W'(MAX_DIM) + IDX_W'(col_q);
  assign a_we     = (state_q == S_LOAD_A) && xfer_done;
  assign b_we     = (state_q == S_LOAD_B) && xfer_done;

  // Capture fetched words into the operand buffers (contents need no reset).
  always_ff @(posedge clk_i) begin
    if (a_we) a_buf_q[wr_idx] <= mem_rdata_i;
    if (b_we) b_buf_q[wr_idx] <= mem_rdata_i;
  end

  // Signed 32x32 product formed as a 64x64 product of sign-extended operands.
  assign op_a    = a_buf_q[a_rd_idx];
  assign op_b    = b_buf_q[b_rd_idx];
  assign prod    = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  assign acc_add = {{(ACC_W-64){prod[63]}}, prod};

  // The accumulator fits in 32 signed bits iff all bits from 31 upward agree.
  assign c_ovf = !((&acc_q[ACC_W-1:31]) || !(|acc_q[ACC_W-1:31]));

`ifdef MATMUL_SAT_EN
  assign c_word = c_ovf ? (acc_q[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF) : acc_q[31:0];
`else
  assign c_word = acc_q[31:0];
`endif

  // Job sequencer: config latch, bus handshakes, MAC and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ph_q       <= PH_ISSUE;
      m_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      base_c_q   <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
      stride_c_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      kk_q       <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef MATMUL_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (dims_ok) begin
              m_q        <= dim_m_i;
              k_q        <= dim_k_i;
              n_q        <= dim_n_i;
              base_a_q   <= addr_a_i;
              base_b_q   <= addr_b_i;
              base_c_q   <= addr_c_i;
              stride_a_q <= stride_a_i;
              stride_b_q <= stride_b_i;
              stride_c_q <= stride_c_i;
              row_q      <= '0;
              col_q      <= '0;
              kk_q       <= '0;
              ph_q       <= PH_ISSUE;
              busy_q     <= 1'b1;
              state_q    <= S_LOAD_A;
`ifdef MATMUL_SAT_EN
              sat_q      <= 1'b0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        S_LOAD_A, S_LOAD_B, S_WRITE: begin
          case (ph_q)
            PH_ISSUE: begin
              req_q   <= 1'b1;
              addr_q  <= elem_addr;
              we_q    <= (state_q == S_WRITE);
              be_q    <= (state_q == S_WRITE) ? 4'hF : 4'h0;
              wdata_q <= (state_q == S_WRITE) ? c_word : 32'h0;
              ph_q    <= PH_REQ;
`ifdef MATMUL_SAT_EN
              if ((state_q == S_WRITE) && c_ovf) sat_q <= 1'b1;
`endif
            end
            PH_REQ: begin
              if (mem_gnt_i) begin
                req_q <= 1'b0;
                ph_q  <= mem_ack_i ? PH_ISSUE : PH_ACK;
              end
            end
            PH_ACK: begin
              if (mem_ack_i) ph_q <= PH_ISSUE;
            end
            default: ph_q <= PH_ISSUE;
          endcase

          if (xfer_done) begin
            if (col_last) begin
              col_q <= '0;
              if (row_last) row_q <= '0;
              else          row_q <= row_q + ONE;
            end else begin
              col_q <= col_q + ONE;
            end

            if (state_q == S_LOAD_A) begin
              if (row_last && col_last) state_q <= S_LOAD_B;
            end else if (state_q == S_LOAD_B) begin
              if (row_last && col_last) begin
                state_q <= S_MAC;
                kk_q    <= '0;
                acc_q   <= '0;
              end
            end else begin
              if (row_last && col_last) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_MAC;
                kk_q    <= '0;
                acc_q   <= '0;
              end
            end
          end
        end

        S_MAC: begin
          acc_q <= acc_q + acc_add;
          if (kk_q == k_q - ONE) begin
            kk_q    <= '0;
            ph_q    <= PH_ISSUE;
            state_q <= S_WRITE;
          end else begin
            kk_q <= kk_q + ONE;
          end
        end

        S_DONE: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_dma_engine.sv
// Testbench for matmul_dma_engine: a bus responder with a word memory, an
// arithmetic reference model of C = A*B, and directed plus randomized jobs.
// Build with +define+MATMUL_SAT_EN to exercise the saturating variant.
module tb_matmul_dma_engine;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  dim_m_i = '0, dim_k_i = '0, dim_n_i = '0;
  logic [31:0] addr_a_i = '0, addr_b_i = '0, addr_c_i = '0;
  logic [15:0] stride_a_i = '0, stride_b_i = '0, stride_c_i = '0;
  logic        busy_o, done_o, err_o;
`ifdef MATMUL_SAT_EN
  logic        sat_o;
`endif
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_gnt_i = 1'b0;
  logic        mem_ack_i = 1'b0;

  matmul_dma_engine dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .dim_m_i(dim_m_i), .dim_k_i(dim_k_i), .dim_n_i(dim_n_i),
    .addr_a_i(addr_a_i), .addr_b_i(addr_b_i), .addr_c_i(addr_c_i),
    .stride_a_i(stride_a_i), .stride_b_i(stride_b_i), .stride_c_i(stride_c_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
`ifdef MATMUL_SAT_EN
    .sat_o(sat_o),
`endif
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_gnt_i(mem_gnt_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus responder and memory ----------------
  logic [31:0] mem [logic [31:0]];
  bit          zero_wait = 1'b1;
  int          gnt_wait = -1;
  int          ack_wait = 0;
  bit          outstanding = 1'b0;
  bit          t_seen = 1'b0;
  logic [31:0] t_addr, t_wdata;
  logic        t_we;
  logic [3:0]  t_be;
  int          n_reads = 0;
  int          n_writes = 0;

  task complete_xfer();
    mem_ack_i = 1'b1;
    if (t_we) begin
      mem[t_addr] = t_wdata;
      n_writes++;
    end else begin
      mem_rdata_i = mem.exists(t_addr) ? mem[t_addr] : 32'hDEAD_BEEF;
      n_reads++;
    end
  endtask

  always @(negedge clk_i) begin
    mem_gnt_i   = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    if (rst_i) begin
      outstanding = 1'b0;
      gnt_wait    = -1;
      t_seen      = 1'b0;
    end else if (outstanding) begin
      check("one_outstanding", 32'(mem_req_o), 32'd0);
      ack_wait--;
      if (ack_wait <= 0) begin
        complete_xfer();
        outstanding = 1'b0;
      end
    end else if (mem_req_o) begin
      if (!t_seen) begin
        t_seen  = 1'b1;
        t_addr  = mem_addr_o;
        t_wdata = mem_wdata_o;
        t_we    = mem_we_o;
        t_be    = mem_be_o;
        gnt_wait = zero_wait ? 0 : int'($urandom_range(0, 5));
        check("be_vs_we", 32'(t_be), t_we ? 32'hF : 32'h0);
      end else begin
        check("hold_addr",  mem_addr_o, t_addr);
        check("hold_wdata", mem_wdata_o, t_wdata);
        check("hold_we_be", {27'd0, mem_we_o, mem_be_o}, {27'd0, t_we, t_be});
      end
      if (gnt_wait == 0) begin
        mem_gnt_i = 1'b1;
        t_seen    = 1'b0;
        if (zero_wait) complete_xfer();
        else begin
          outstanding = 1'b1;
          ack_wait    = int'($urandom_range(1, 4));
        end
      end else begin
        gnt_wait--;
      end
    end
  end

  // ---------------- reference model ----------------
  int a_v [4][4];
  int b_v [4][4];

  function automatic logic [31:0] ref_c(input int i, input int j, input int k);
    longint acc = 0;
    for (int kk = 0; kk < k; kk++) acc += longint'(a_v[i][kk]) * longint'(b_v[kk][j]);
`ifdef MATMUL_SAT_EN
    if (acc > 64'sd2147483647) acc = 64'sd2147483647;
    if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`endif
    return acc[31:0];
  endfunction

  function automatic logic [31:0] eaddr(input logic [31:0] base, input logic [15:0] stride,
                                        input int r, input int c);
    return base + 32'(r) * 32'(stride) + 32'(4 * c);
  endfunction

  task automatic randomize_mats();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a_v[r][c] = int'($urandom_range(0, 65535)) - 32768;
        b_v[r][c] = int'($urandom_range(0, 65535)) - 32768;
      end
  endtask

  task automatic load_mem(input int m, input int k, input int n,
                          input logic [31:0] aa, input logic [31:0] ab, input logic [31:0] ac,
                          input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] sc);
    for (int i = 0; i < m; i++) for (int c = 0; c < k; c++) mem[eaddr(aa, sa, i, c)] = a_v[i][c];
    for (int r = 0; r < k; r++) for (int j = 0; j < n; j++) mem[eaddr(ab, sb, r, j)] = b_v[r][j];
    for (int i = 0; i < m; i++) for (int j = 0; j < n; j++) mem.delete(eaddr(ac, sc, i, j));
  endtask

  task automatic drive_start(input int m, input int k, input int n,
                             input logic [31:0] aa, input logic [31:0] ab, input logic [31:0] ac,
                             input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] sc);
    @(posedge clk_i); #1;
    dim_m_i = 3'(m); dim_k_i = 3'(k); dim_n_i = 3'(n);
    addr_a_i = aa; addr_b_i = ab; addr_c_i = ac;
    stride_a_i = sa; stride_b_i = sb; stride_c_i = sc;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic run_job(input string name, input int m, input int k, input int n,
                         input logic [31:0] aa, input logic [31:0] ab, input logic [31:0] ac,
                         input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] sc,
                         input bit inject);
    int rd0, wr0, dones, post, errs;
    bit injected;
    load_mem(m, k, n, aa, ab, ac, sa, sb, sc);
    rd0 = n_reads; wr0 = n_writes; dones = 0; post = 0; injected = 0; errs = 0;
    drive_start(m, k, n, aa, ab, ac, sa, sb, sc);
    check({name, "_busy_after_start"}, 32'(busy_o), 32'd1);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (err_o) errs++;
      if (done_o) begin
        if (dones == 0) check({name, "_busy_in_done"}, 32'(busy_o), 32'd0);
        dones++;
      end
      if (dones > 0) post++;
      if (post == 4) break;
      if (inject && !injected && (n_reads - rd0 == m * k + k * n)) begin
        addr_a_i = 32'h9000; addr_b_i = 32'hA000; addr_c_i = 32'h8000;
        dim_m_i = 3'd1; dim_k_i = 3'd1; dim_n_i = 3'd1;
        start_i = 1'b1;
        injected = 1'b1;
      end
    end
    check({name, "_done_pulses"}, 32'(dones), 32'd1);
    check({name, "_no_err"}, 32'(errs), 32'd0);
    check({name, "_read_count"}, 32'(n_reads - rd0), 32'(m * k + k * n));
    check({name, "_write_count"}, 32'(n_writes - wr0), 32'(m * n));
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        logic [31:0] ad;
        ad = eaddr(ac, sc, i, j);
        check($sformatf("%s_C%0d%0d", name, i, j), mem.exists(ad) ? mem[ad] : 32'hDEAD_BEEF,
              ref_c(i, j, k));
      end
    if (inject) begin
      check({name, "_inject_seen"}, 32'(injected), 32'd1);
      check({name, "_alt_c_untouched"}, 32'(mem.exists(32'h8000)), 32'd0);
    end
    $display("job %s: M=%0d K=%0d N=%0d C@%08h done=%0d checks=%0d", name, m, k, n, ac, dones, chk_cnt);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rd0;
    int exp1 [4];
    exp1 = '{58, 64, 139, 154};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err",  32'(err_o),  32'd0);
    check("rst_req",  32'(mem_req_o), 32'd0);
    check("rst_we_be", {27'd0, mem_we_o, mem_be_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    rst_i = 1'b0;

    // Job 1: textbook 2x3 * 3x2, zero-wait bus.
    a_v[0][0] = 1; a_v[0][1] = 2; a_v[0][2] = 3;
    a_v[1][0] = 4; a_v[1][1] = 5; a_v[1][2] = 6;
    b_v[0][0] = 7; b_v[0][1] = 8; b_v[1][0] = 9; b_v[1][1] = 10; b_v[2][0] = 11; b_v[2][1] = 12;
    zero_wait = 1'b1;
    run_job("t1", 2, 3, 2, 32'h100, 32'h200, 32'h300, 16'd12, 16'd8, 16'd8, 1'b0);
    for (int e = 0; e < 4; e++)
      check($sformatf("t1_const_C%0d", e), mem[eaddr(32'h300, 16'd8, e / 2, e % 2)], 32'(exp1[e]));

    // Job 2: same job with random grant/ack latency.
    zero_wait = 1'b0;
    run_job("t2", 2, 3, 2, 32'h100, 32'h200, 32'h400, 16'd12, 16'd8, 16'd8, 1'b0);

    // Rejected starts: K=0, then M=MAX_DIM+1.
    for (int t = 0; t < 2; t++) begin
      drive_start((t == 0) ? 2 : 5, (t == 0) ? 0 : 2, 2,
                  32'h100, 32'h200, 32'h500, 16'd8, 16'd8, 16'd8);
      check($sformatf("t3_err_pulse%0d", t), 32'(err_o), 32'd1);
      check($sformatf("t3_busy%0d", t), 32'(busy_o), 32'd0);
      @(posedge clk_i); #1;
      check($sformatf("t3_err_single%0d", t), 32'(err_o), 32'd0);
      for (int c = 0; c < 4; c++) begin
        check($sformatf("t3_req_idle%0d", t), 32'(mem_req_o), 32'd0);
        check($sformatf("t3_busy_idle%0d", t), 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;
      end
      $display("job t3_%0d: rejected start, err pulse observed", t);
    end

    // 1x1x1 overflow: truncation or saturation depending on build.
    a_v[0][0] = 32'h7FFF_FFFF; b_v[0][0] = 2;
    run_job("t4", 1, 1, 1, 32'h600, 32'h610, 32'h620, 16'd4, 16'd4, 16'd4, 1'b0);
`ifdef MATMUL_SAT_EN
    check("t4_C_const", mem[32'h620], 32'h7FFF_FFFF);
    check("t4_sat", 32'(sat_o), 32'd1);
`else
    check("t4_C_const", mem[32'h620], 32'hFFFF_FFFE);
`endif

    // Reset during LOAD_B aborts the job with no done pulse.
    randomize_mats();
    load_mem(2, 2, 2, 32'h700, 32'h780, 32'h7C0, 16'd8, 16'd8, 16'd8);
    rd0 = n_reads;
    drive_start(2, 2, 2, 32'h700, 32'h780, 32'h7C0, 16'd8, 16'd8, 16'd8);
    for (int cyc = 0; cyc < 2000 && (n_reads - rd0) < 5; cyc++) begin
      @(posedge clk_i); #1;
    end
    check("t5_reached_load_b", 32'(n_reads - rd0 >= 5), 32'd1);
    rst_i = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy_o), 32'd0);
    check("t5_rst_req", 32'(mem_req_o), 32'd0);
    check("t5_rst_addr", mem_addr_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    check("t5_rst_done", 32'(done_o), 32'd0);
    rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i); #1;
      check("t5_no_done", 32'(done_o | mem_req_o), 32'd0);
    end
    a_v[0][0] = 3; b_v[0][0] = -4;
    run_job("t5", 1, 1, 1, 32'h800, 32'h810, 32'h820, 16'd4, 16'd4, 16'd4, 1'b0);
    check("t5_C_const", mem[32'h820], 32'hFFFF_FFF4);
`ifdef MATMUL_SAT_EN
    check("t5_sat_cleared", 32'(sat_o), 32'd0);
`endif

    // Start pulsed during MAC with other addresses is ignored.
    randomize_mats();
    run_job("t6", 3, 3, 3, 32'h1000, 32'h2000, 32'h3000, 16'd12, 16'd16, 16'd12, 1'b1);

    // Randomized jobs; the last one places C across the 32-bit address wrap.
    for (int t = 0; t < 6; t++) begin
      int m, k, n;
      logic [31:0] ac;
      m = int'($urandom_range(1, 4));
      k = int'($urandom_range(1, 4));
      n = int'($urandom_range(1, 4));
      zero_wait = ($urandom_range(0, 1) == 0);
      ac = (t == 5) ? 32'hFFFF_FFF0 : 32'h3000 + 32'(t * 256);
      randomize_mats();
      run_job($sformatf("r%0d", t), m, k, n, 32'h1000, 32'h2000, ac,
              16'(4 * k + 4 * int'($urandom_range(0, 3))),
              16'(4 * n + 4 * int'($urandom_range(0, 3))),
              16'(4 * n + 4 * int'($urandom_range(0, 3))), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
